// File: rtl/exu_cal_arb_pkg.sv
// Shared types and constants for the calculator arbiter slice.
package exu_cal_arb_pkg;

  localparam int CAL_OPB_SIZE = 16;

  typedef enum logic [1:0] {
    CARB_IDLE  = 2'd0,
    CARB_BUSY  = 2'd1,
    CARB_DONE  = 2'd2,
    CARB_DRAIN = 2'd3
  } carb_state_e;

  // Index width that stays legal for a single channel.
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/exu_cal_arb_rr_pick.sv
// Combinational round-robin picker: first set request at or above ptr, wrapping.
module exu_rr_pick
  import exu_cal_arb_pkg::*;
#(
  parameter int NCH = 3,
  localparam int IW = idx_w(NCH)
) (
  input  logic [NCH-1:0] req,
  input  logic [IW-1:0]  ptr,
  output logic [NCH-1:0] gnt,
  output logic [IW-1:0]  idx
);

  always_comb begin
    int   c;
    logic found;
    // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
    gnt   = '0;
    idx   = '0;
    found = 1'b0;
    c     = 0;
    for (int i = 0; i < NCH; i++) begin
      c = (int'(ptr) + i) % NCH;
      if (!found && req[c]) begin
        found  = 1'b1;
        gnt[c] = 1'b1;
        idx    = IW'(c);
      end
    end
  end

endmodule

// File: rtl/exu_cal_arb.sv
// Round-robin arbiter sharing one multi-cycle calculator between NCH sub-units,
// with abort/flush handling while the calculator is busy.
module exu_cal_arb
  import exu_cal_arb_pkg::*;
#(
  parameter int NCH   = 3,
  parameter int OPB_W = CAL_OPB_SIZE,
  parameter int DW    = 32,
  parameter int CW    = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               i_flush,
  input  logic [NCH-1:0]     hs_req_val,
  output logic [NCH-1:0]     hs_req_rdy,
  input  logic [NCH*OPB_W-1:0] i_req_opb,
  output logic [DW-1:0]      o_res,
  output logic               hs_arb4cal_val,
  input  logic               hs_cal4arb_rdy,
  output logic [OPB_W-1:0]   o_cal_opb,
  input  logic [DW-1:0]      i_cal_res,
  output logic [NCH-1:0]     o_gnt,
  output logic               o_busy,
  output logic [CW-1:0]      o_stall_cnt
);

  localparam int IW = idx_w(NCH);

  carb_state_e      state_q, state_d;
  logic [IW-1:0]    gnt_q, gnt_d;
  logic [IW-1:0]    ptr_q, ptr_d;
  logic [OPB_W-1:0] opb_q, opb_d;
  logic [DW-1:0]    res_q, res_d;
  logic [CW-1:0]    stall_q;
  logic [NCH-1:0]   pick_gnt;
  logic [IW-1:0]    pick_idx;
  logic [OPB_W-1:0] opb_arr [NCH];
  logic             withdraw;
  logic             stall_hit;

  for (genvar i = 0; i < NCH; i++) begin : g_opb
    assign opb_arr[i] = i_req_opb[i*OPB_W +: OPB_W];
  end

  exu_rr_pick #(.NCH(NCH)) u_pick (
    .req (hs_req_val),
    .ptr (ptr_q),
    .gnt (pick_gnt),
    .idx (pick_idx)
  );

  always_comb begin
    o_gnt = '0;
    if (state_q != CARB_IDLE) o_gnt[gnt_q] = 1'b1;
  end

  assign withdraw       = !hs_req_val[gnt_q] || i_flush;
  assign hs_arb4cal_val = (state_q == CARB_BUSY) || (state_q == CARB_DRAIN);
  assign o_busy         = (state_q != CARB_IDLE);
  assign hs_req_rdy     = (state_q == CARB_DONE && !i_flush) ? o_gnt : '0;
  assign o_cal_opb      = opb_q;
  assign o_res          = res_q;
  assign o_stall_cnt    = stall_q;
  assign stall_hit      = |(hs_req_val & ~o_gnt);

  always_comb begin
    state_d = state_q;
    gnt_d   = gnt_q;
    ptr_d   = ptr_q;
    opb_d   = opb_q;
    res_d   = res_q;
    unique case (state_q)
      CARB_IDLE: begin
        if (!i_flush && |pick_gnt) begin
          gnt_d   = pick_idx;
          opb_d   = opb_arr[pick_idx];
          state_d = CARB_BUSY;
        end
      end
      CARB_BUSY: begin
        if (hs_cal4arb_rdy) begin
          if (withdraw) begin
            state_d = CARB_IDLE;
          end else begin
            res_d   = i_cal_res;
            state_d = CARB_DONE;
          end
        end else if (withdraw) begin
          state_d = CARB_DRAIN;
        end
      end
      // The calculator cannot be aborted, so its handshake is completed and the result dropped.
      CARB_DRAIN: begin
        if (hs_cal4arb_rdy) state_d = CARB_IDLE;
      end
      CARB_DONE: begin
        ptr_d   = (gnt_q == IW'(NCH - 1)) ? '0 : gnt_q + IW'(1);
        state_d = CARB_IDLE;
      end
      default: state_d = CARB_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= CARB_IDLE;
      gnt_q   <= '0;
      ptr_q   <= '0;
      opb_q   <= '0;
      res_q   <= '0;
      stall_q <= '0;
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      ptr_q   <= ptr_d;
      opb_q   <= opb_d;
      res_q   <= res_d;
      if (stall_hit && stall_q != '1) stall_q <= stall_q + CW'(1);
    end
  end

endmodule

// File: tb/tb_exu_cal_arb.sv
// Directed bench for exu_cal_arb with a behavioural calculator and a completion scoreboard.
module tb_exu_cal_arb;

  localparam int NCH   = 3;
  localparam int OPB_W = 16;
  localparam int DW    = 32;
  localparam int CW    = 16;

  logic               clk;
  logic               rst;
  logic               i_flush;
  logic [NCH-1:0]     hs_req_val;
  logic [NCH-1:0]     hs_req_rdy;
  logic [NCH*OPB_W-1:0] i_req_opb;
  logic [DW-1:0]      o_res;
  logic               hs_arb4cal_val;
  logic               hs_cal4arb_rdy;
  logic [OPB_W-1:0]   o_cal_opb;
  logic [DW-1:0]      i_cal_res;
  logic [NCH-1:0]     o_gnt;
  logic               o_busy;
  logic [CW-1:0]      o_stall_cnt;

  exu_cal_arb #(.NCH(NCH), .OPB_W(OPB_W), .DW(DW), .CW(CW)) dut (
    .clk            (clk),
    .rst            (rst),
    .i_flush        (i_flush),
    .hs_req_val     (hs_req_val),
    .hs_req_rdy     (hs_req_rdy),
    .i_req_opb      (i_req_opb),
    .o_res          (o_res),
    .hs_arb4cal_val (hs_arb4cal_val),
    .hs_cal4arb_rdy (hs_cal4arb_rdy),
    .o_cal_opb      (o_cal_opb),
    .i_cal_res      (i_cal_res),
    .o_gnt          (o_gnt),
    .o_busy         (o_busy),
    .o_stall_cnt    (o_stall_cnt)
  );

  typedef struct {
    int          chan;
    logic [31:0] res;
  } exp_t;

  exp_t sb[$];
  int   n_cmp = 0;
  int   n_bad = 0;
  int   cyc   = 0;
  int   cal_delay = 0;
  int   c0;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [31:0] exp_res(input logic [15:0] opb);
    return 32'hDEADBEEA ^ {16'h0, opb};
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic set_opb(input int ch, input logic [15:0] v);
    i_req_opb[ch*OPB_W +: OPB_W] = v;
  endtask

  task automatic push(input int ch, input logic [31:0] r);
    exp_t e;
    e.chan = ch;
    e.res  = r;
    sb.push_back(e);
  endtask

  task automatic start(input logic [NCH-1:0] vals, input int delay, output int t0);
    @(posedge clk); #1;
    cal_delay  = delay;
    hs_req_val = hs_req_val | vals;
    t0 = cyc;
  endtask

  task automatic wait_pulse(input int ch, input bit drop, input int t0, input int lat, input string name);
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!hs_req_rdy[ch] && n < 60);
    if (!hs_req_rdy[ch]) begin
      check({name, "_timeout"}, 64'(n), 64'(lat));
    end else begin
      check(name, 64'(cyc - t0), 64'(lat));
      if (drop) hs_req_val[ch] = 1'b0;
    end
  endtask

  // Calculator: raises rdy after cal_delay cycles of val, result derived from the opb.
  initial begin
    int cnt;
    cnt = 0;
    hs_cal4arb_rdy = 1'b0;
    i_cal_res = '0;
    forever begin
      @(negedge clk);
      if (hs_arb4cal_val) begin
        hs_cal4arb_rdy = (cnt == cal_delay);
        i_cal_res = hs_cal4arb_rdy ? exp_res(o_cal_opb) : 32'h0;
        cnt++;
      end else begin
        hs_cal4arb_rdy = 1'b0;
        i_cal_res = '0;
        cnt = 0;
      end
    end
  end

  // Completion monitor: every pulse must match the head of the scoreboard.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (!rst && hs_req_rdy != '0) begin
        if (sb.size() == 0) begin
          check("unexpected_pulse", 64'(hs_req_rdy), 64'(0));
        end else begin
          e = sb.pop_front();
          check("pulse_chan", 64'(hs_req_rdy), 64'(3'b001 << e.chan));
          check("pulse_res", 64'(o_res), 64'(e.res));
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: stimulus did not complete");
    $fatal(1);
  end

  initial begin
    rst        = 1'b1;
    i_flush    = 1'b0;
    hs_req_val = '0;
    i_req_opb  = '0;
    #12;
    check("rst_rdy",   64'(hs_req_rdy), 64'(0));
    check("rst_calval", 64'({hs_arb4cal_val, o_busy, o_gnt}), 64'(0));
    check("rst_data",  64'({o_res, o_cal_opb, o_stall_cnt}), 64'(0));
    @(negedge clk);
    rst = 1'b0;

    // All three channels at once, immediate calculator: ch0, ch1, ch2 at 2, 5, 8.
    set_opb(0, 16'h10); set_opb(1, 16'h11); set_opb(2, 16'h12);
    push(0, exp_res(16'h10)); push(1, exp_res(16'h11)); push(2, exp_res(16'h12));
    start(3'b111, 0, c0);
    @(negedge clk);
    @(negedge clk);
    check("sim_gnt_c1", 64'(o_gnt), 64'(3'b001));
    wait_pulse(0, 1, c0, 2, "sim_lat_ch0");
    wait_pulse(1, 1, c0, 5, "sim_lat_ch1");
    wait_pulse(2, 1, c0, 8, "sim_lat_ch2");
    check("sim_stall", 64'(o_stall_cnt), 64'(7));

    // Single request on ch1 with a 3-cycle calculator.
    set_opb(1, 16'h05);
    push(1, 32'hDEADBEEF);
    start(3'b010, 3, c0);
    @(negedge clk);
    @(negedge clk);
    check("single_calval", 64'({hs_arb4cal_val, o_busy, o_gnt}), 64'({1'b1, 1'b1, 3'b010}));
    check("single_opb", 64'(o_cal_opb), 64'(16'h05));
    wait_pulse(1, 1, c0, 5, "single_lat");
    check("single_stall", 64'(o_stall_cnt), 64'(8));

    // Pointer at 2: ch2 first; ch2 keeps val so ch0 must come before it again.
    set_opb(0, 16'h20); set_opb(2, 16'h22);
    push(2, exp_res(16'h22)); push(0, exp_res(16'h20)); push(2, exp_res(16'h22));
    start(3'b101, 1, c0);
    wait_pulse(2, 0, c0, 3, "wrap_lat_ch2a");
    wait_pulse(0, 1, c0, 7, "wrap_lat_ch0");
    wait_pulse(2, 1, c0, 11, "wrap_lat_ch2b");

    // Withdraw during BUSY: drain until calculator rdy, no pulse, o_res untouched.
    set_opb(0, 16'h30);
    start(3'b001, 5, c0);
    @(posedge clk); #1;
    @(posedge clk); #1;
    hs_req_val[0] = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check("drain_state", 64'({hs_arb4cal_val, o_busy, hs_req_rdy}), 64'({1'b1, 1'b1, 3'b000}));
    begin
      int n;
      n = 0;
      while (hs_arb4cal_val && n < 40) begin
        @(negedge clk);
        n++;
      end
    end
    check("drain_release_cyc", 64'(cyc - c0), 64'(7));
    check("drain_res_hold", 64'(o_res), 64'(exp_res(16'h22)));
    check("drain_idle", 64'(o_busy), 64'(0));
    set_opb(1, 16'h31);
    push(1, exp_res(16'h31));
    start(3'b010, 0, c0);
    wait_pulse(1, 1, c0, 2, "after_drain_lat");

    // Flush on the DONE cycle: no pulse, pointer still moves from 2 to 1.
    set_opb(0, 16'h40);
    start(3'b001, 0, c0);
    @(posedge clk); #1;
    @(posedge clk); #1;
    i_flush = 1'b1;
    @(negedge clk);
    check("flush_done_rdy", 64'({o_busy, hs_req_rdy}), 64'({1'b1, 3'b000}));
    check("flush_done_res", 64'(o_res), 64'(exp_res(16'h40)));
    @(posedge clk); #1;
    i_flush = 1'b0;
    hs_req_val[0] = 1'b0;
    set_opb(0, 16'h60); set_opb(1, 16'h61);
    push(1, exp_res(16'h61)); push(0, exp_res(16'h60));
    start(3'b011, 0, c0);
    wait_pulse(1, 1, c0, 2, "ptr_adv_ch1");
    wait_pulse(0, 1, c0, 5, "ptr_adv_ch0");

    // Asynchronous reset in the middle of BUSY.
    set_opb(2, 16'h50);
    start(3'b100, 10, c0);
    @(negedge clk);
    @(negedge clk);
    check("pre_rst_busy", 64'({hs_arb4cal_val, o_gnt}), 64'({1'b1, 3'b100}));
    #2;
    rst = 1'b1;
    #1;
    check("async_rst_ctl", 64'({hs_arb4cal_val, o_busy, o_gnt, hs_req_rdy}), 64'(0));
    check("async_rst_stall", 64'(o_stall_cnt), 64'(0));
    hs_req_val = '0;
    @(negedge clk);
    rst = 1'b0;
    set_opb(1, 16'h51);
    push(1, exp_res(16'h51));
    start(3'b010, 0, c0);
    wait_pulse(1, 1, c0, 2, "post_rst_lat");

    repeat (3) @(negedge clk);
    check("sb_empty", 64'(sb.size()), 64'(0));
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
